// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the sum_accumulator burst-total stage.
// Holds the FSM state encoding and the counter-width helper.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } sum_acc_state_t;

  // Bits needed to hold the values 0..value inclusive, i.e. $clog2(value+1).
  function automatic int clog2_plus1(input int value);
    int result;
    result = 0;
    while ((1 << result) < (value + 1)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sum_accumulator_adder.sv
// Shared N-bit adder: unsigned a + b with the carry returned as the top sum bit.
// The accumulator instantiates it at the accumulator width.
module sum_accumulator_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates K consecutive (N+1)-bit sums into one burst total with valid/ready on both sides.
// Optional early-close input `flush` is present only when SUM_ACC_FLUSH_EN is defined.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int K     = 4,
  localparam int ACC_W = N + 1 + $clog2(K),
  localparam int CNT_W = clog2_plus1(K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_cnt,
`ifdef SUM_ACC_FLUSH_EN
  input  logic             flush,
`endif
  output logic             busy
);

  sum_acc_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             last_sample;
  logic             flush_req;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   add_sum;
  logic             unused_carry;

`ifdef SUM_ACC_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready    = (state_q != HOLD);
  assign accept      = in_valid && in_ready;
  assign sum_ext     = ACC_W'(in_sum);
  assign last_sample = accept && (cnt_q == CNT_W'(K - 1));

  // A flush without a same-cycle sample must close on acc alone, so the addend is gated.
  assign addend = accept ? sum_ext : '0;

  sum_accumulator_adder #(
    .N (ACC_W)
  ) u_adder (
    .a   (acc_q),
    .b   (addend),
    .sum (add_sum)
  );

  // K*(2^(N+1)-1) always fits in ACC_W bits, so the carry out is never set.
  assign unused_carry = add_sum[ACC_W];

  // NOTE: every variable is given its hold value before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = sum_ext;
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (last_sample || flush_req) begin
          total_d     = add_sum[ACC_W-1:0];
          out_cnt_d   = cnt_q + CNT_W'(accept);
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = HOLD;
        end else if (accept) begin
          acc_d = add_sum[ACC_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_total = total_q;
  assign out_cnt   = out_cnt_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator at N=8, K=4; flush scenarios build with SUM_ACC_FLUSH_EN.
module tb_sum_accumulator;

  localparam int N     = 8;
  localparam int K     = 4;
  localparam int ACC_W = N + 1 + $clog2(K);
  localparam int CNT_W = $clog2(K + 1);

  typedef struct {
    logic [ACC_W-1:0] total;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_cnt;
  logic             busy;
`ifdef SUM_ACC_FLUSH_EN
  logic             flush;
`endif

  exp_t sb_q[$];
  int   model_acc;
  int   model_cnt;
  int   pass_cnt;
  int   total_cnt;

  sum_accumulator #(
    .N (N),
    .K (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_cnt   (out_cnt),
`ifdef SUM_ACC_FLUSH_EN
    .flush     (flush),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    model_acc = 0;
    model_cnt = 0;
  endtask

  task automatic model_accept(input int v);
    exp_t e;
    model_acc = model_acc + v;
    model_cnt = model_cnt + 1;
    if (model_cnt == K) begin
      e.total = ACC_W'(model_acc);
      e.cnt   = CNT_W'(K);
      sb_q.push_back(e);
      model_clear();
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic drive_sample(input int v);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_sum   = (N+1)'(v);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL drive_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      model_accept(v);
    end
  endtask

  task automatic pop_and_compare(input string name);
    int   waited;
    exp_t e;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s_timeout: out_valid=%b, required 1", name, out_valid);
    end else if (sb_q.size() == 0) begin
      $display("FAIL %s_unexpected: out_valid=1 with empty scoreboard, required no output", name);
    end else begin
      pass_cnt++;
      e = sb_q.pop_front();
      total_cnt++;
      if (out_total !== e.total)
        $display("FAIL %s_total: got %0d, required %0d", name, out_total, e.total);
      else pass_cnt++;
      total_cnt++;
      if (out_cnt !== e.cnt)
        $display("FAIL %s_cnt: got %0d, required %0d", name, out_cnt, e.cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_total !== '0) $display("FAIL reset_out_total: got %0d, required 0", out_total);
    else pass_cnt++;
    total_cnt++;
    if (out_cnt !== '0) $display("FAIL reset_out_cnt: got %0d, required 0", out_cnt);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive_sample(10);
    drive_sample(20);
    drive_sample(30);
    drive_sample(40);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%b, required 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL basic_hold_ready: in_ready=%b, required 0", in_ready);
    else pass_cnt++;
    pop_and_compare("basic");
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready_back: in_ready=%b, required 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: out_valid=%b, required 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_max();
    for (int i = 0; i < K; i++) drive_sample(511);
    pop_and_compare("max");
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL max_valid_drop: out_valid=%b, required 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] held;
    out_ready = 1'b0;
    drive_sample(1);
    drive_sample(2);
    drive_sample(3);
    drive_sample(4);
    held     = (sb_q.size() != 0) ? sb_q[0].total : '0;
    in_valid = 1'b1;
    in_sum   = (N+1)'(99);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b, required 1", i, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (out_total !== held) $display("FAIL bp_total_%0d: got %0d, required %0d", i, out_total, held);
      else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b, required 0", i, in_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop_and_compare("bp");
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b, required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL bp_blocked_accept: busy=%b, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive_sample(3);
    drive_sample(4);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rmid_busy: got %b, required 1", busy);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rmid_async_busy: got %b, required 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    for (int i = 0; i < K; i++) drive_sample(1);
    pop_and_compare("rmid");
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic pat [7];
    int   vals [4];
    int   k;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vals = '{5, 6, 7, 8};
    k    = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      if (pat[i]) begin
        in_sum = (N+1)'(vals[k]);
        model_accept(vals[k]);
        k++;
      end else begin
        in_sum = (N+1)'(77);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop_and_compare("gaps");
    @(negedge clk);
  endtask

`ifdef SUM_ACC_FLUSH_EN
  task automatic test_flush();
    exp_t e;
    drive_sample(5);
    in_valid = 1'b1;
    in_sum   = (N+1)'(6);
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    e.total  = ACC_W'(11);
    e.cnt    = CNT_W'(2);
    sb_q.push_back(e);
    model_clear();
    pop_and_compare("flush");
    @(negedge clk);
    flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_idle_valid: got %b, required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_idle_busy: got %b, required 0", busy);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    model_clear();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
`ifdef SUM_ACC_FLUSH_EN
    flush     = 1'b0;
`endif
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_gaps();
`ifdef SUM_ACC_FLUSH_EN
    test_flush();
`endif
    repeat (2) @(negedge clk);
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: %0d results pending, required 0", sb_q.size());
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL final_idle: out_valid=%b, required 0", out_valid);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
